// File: rtl/tl_pkg.sv
// Shared types, lamp codes and phase helpers for the two-road traffic controller.
package tl_pkg;

   typedef enum logic [2:0] {
      AG  = 3'd0,
      AY  = 3'd1,
      RR1 = 3'd2,
      BG  = 3'd3,
      BY  = 3'd4,
      RR2 = 3'd5
   } phase_e;

   localparam logic [2:0] LAMP_RED = 3'b001;
   localparam logic [2:0] LAMP_GRN = 3'b010;
   localparam logic [2:0] LAMP_YEL = 3'b100;

   // Durations live in the top's parameters, so they are passed in explicitly.
   function automatic int unsigned dur_of(phase_e      ph,
                                          int unsigned green_a,
                                          int unsigned green_b,
                                          int unsigned yellow,
                                          int unsigned all_red);
      int unsigned d;
      case (ph)
         AG:       d = green_a;
         AY, BY:   d = yellow;
         BG:       d = green_b;
         RR1, RR2: d = all_red;
         default:  d = green_a;
      endcase
      return d;
   endfunction

   function automatic phase_e next_phase(phase_e ph);
      phase_e n;
      case (ph)
         AG:      n = AY;
         AY:      n = RR1;
         RR1:     n = BG;
         BG:      n = BY;
         BY:      n = RR2;
         default: n = AG;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/traffic_ctrl_param_if.sv
// Control inputs and lamp/display outputs of the traffic controller.
interface traffic_ctrl_param_if #(
   parameter int unsigned CNT_W = 8
);
   logic             manual;
   logic             step;
   logic             ped_req;
   logic [2:0]       A;
   logic [2:0]       B;
   logic [2:0]       phase;
   logic [CNT_W-1:0] count;
   logic [3:0]       cnt_ones;
   logic [3:0]       cnt_tens;
   logic             tick;
   logic             ped_ack;

   modport master (
      output manual, step, ped_req,
      input  A, B, phase, count, cnt_ones, cnt_tens, tick, ped_ack
   );

   modport slave (
      input  manual, step, ped_req,
      output A, B, phase, count, cnt_ones, cnt_tens, tick, ped_ack
   );
endinterface

// File: rtl/bin2bcd.sv
// Binary to two-digit BCD for the seg7 display path (meaningful for values up to 99).
module bin2bcd #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] bin,
   output logic [3:0]   ones,
   output logic [3:0]   tens
);
   logic [W-1:0] w_quot;
   logic [W-1:0] w_rem;

   assign w_quot = bin / W'(10);
   assign w_rem  = bin % W'(10);
   assign tens   = w_quot[3:0];
   assign ones   = w_rem[3:0];
endmodule

// File: rtl/tl_tick_gen.sv
// Free-running prescaler; tick is high in the last cycle of each TICK_DIV-cycle period.
module tl_tick_gen #(
   parameter int unsigned TICK_DIV = 25000000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == PW'(TICK_DIV - 1));
   assign tick   = w_last;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + PW'(1);
      end
   end
endmodule

// File: rtl/traffic_ctrl_param.sv
// Two-road traffic-light controller: timed/manual sequencing, all-red clearance,
// pedestrian green shortening and BCD countdown for the display.
module traffic_ctrl_param
   import tl_pkg::*;
#(
   parameter int unsigned TICK_DIV = 25000000,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned GREEN_A  = 8,
   parameter int unsigned GREEN_B  = 5,
   parameter int unsigned YELLOW   = 3,
   parameter int unsigned ALL_RED  = 1,
   parameter int unsigned PED_CUT  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   traffic_ctrl_param_if.slave  bus
);

   phase_e           r_phase;
   logic [CNT_W-1:0] r_count;
   logic             r_ped_pend;
   logic             r_step_q;
   logic             r_manual_q;
   logic             r_ped_ack;

   logic             w_tick;
   phase_e           w_next;
   logic [CNT_W-1:0] w_dur_cur;
   logic [CNT_W-1:0] w_dur_nxt;
   logic             w_legal;
   logic             w_green;
   logic             w_pend_eff;
   logic             w_mode_exit;
   logic             w_timed;
   logic             w_step_edge;
   logic             w_short;
   logic             w_tick_dec;
   logic             w_tick_adv;
   logic             w_advance;
   logic             w_enter_yel;

   tl_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   bin2bcd #(
      .W(CNT_W)
   ) u_bcd (
      .bin  (r_count),
      .ones (bus.cnt_ones),
      .tens (bus.cnt_tens)
   );

   assign w_next    = next_phase(r_phase);
   assign w_dur_cur = CNT_W'(dur_of(r_phase, GREEN_A, GREEN_B, YELLOW, ALL_RED));
   assign w_dur_nxt = CNT_W'(dur_of(w_next, GREEN_A, GREEN_B, YELLOW, ALL_RED));
   assign w_legal   = (r_phase <= RR2);
   assign w_green   = (r_phase == AG) || (r_phase == BG);

   // A request arriving this cycle is acted on at once, not a cycle later.
   assign w_pend_eff  = r_ped_pend | bus.ped_req;
   assign w_mode_exit = r_manual_q & ~bus.manual;
   assign w_timed     = ~bus.manual & ~w_mode_exit;
   assign w_step_edge = bus.manual & bus.step & ~r_step_q;
   assign w_short     = w_timed & w_green & w_pend_eff & (r_count > CNT_W'(PED_CUT));
   assign w_tick_dec  = w_timed & ~w_short & w_tick & (r_count > CNT_W'(1));
   assign w_tick_adv  = w_timed & ~w_short & w_tick & (r_count <= CNT_W'(1));
   assign w_advance   = w_step_edge | w_tick_adv;
   assign w_enter_yel = w_advance & ((w_next == AY) || (w_next == BY));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_phase    <= AG;
         r_count    <= CNT_W'(GREEN_A);
         r_ped_pend <= 1'b0;
         r_step_q   <= 1'b0;
         r_manual_q <= 1'b0;
         r_ped_ack  <= 1'b0;
      end else begin
         r_step_q   <= bus.step;
         r_manual_q <= bus.manual;
         r_ped_ack  <= w_short;
         r_ped_pend <= w_pend_eff & ~w_short & ~w_enter_yel;
         if (!w_legal) begin
            r_phase <= AG;
            r_count <= CNT_W'(GREEN_A);
         end else if (w_mode_exit) begin
            r_count <= w_dur_cur;
         end else if (w_advance) begin
            r_phase <= w_next;
            r_count <= w_dur_nxt;
         end else if (w_short) begin
            r_count <= CNT_W'(PED_CUT);
         end else if (w_tick_dec) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   always_comb begin
      bus.A = LAMP_RED;
      bus.B = LAMP_RED;
      case (r_phase)
         AG: bus.A = LAMP_GRN;
         AY: bus.A = LAMP_YEL;
         BG: bus.B = LAMP_GRN;
         BY: bus.B = LAMP_YEL;
         default: ;
      endcase
   end

   assign bus.phase   = r_phase;
   assign bus.count   = r_count;
   assign bus.tick    = w_tick;
   assign bus.ped_ack = r_ped_ack;

endmodule
